// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

  localparam int ARB_NUM_REQ    = 2;
  localparam int ARB_DATA_WIDTH = 64;
  localparam int BE_WIDTH       = ARB_DATA_WIDTH / 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; the pointer only advances on contention.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // A lone requester is served without disturbing the fairness order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one byte-enable single-port SRAM between two requesters, with a
// zero-fill sweep after reset or on request before normal arbitration.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                    NUM_WORDS     = 256,
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = ARB_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                                     Clk_CI,
  input  logic                                     Rst_RI,
  input  logic                                     Init_SI,
  output logic                                     InitDone_SO,
  input  logic [ARB_NUM_REQ-1:0]                   Req_SI,
  output logic [ARB_NUM_REQ-1:0]                   Gnt_SO,
  input  logic [ARB_NUM_REQ-1:0]                   WrEn_SI,
  input  logic [ARB_NUM_REQ-1:0][DATA_WIDTH/8-1:0] BEn_SI,
  input  logic [ARB_NUM_REQ-1:0][ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [ARB_NUM_REQ-1:0][DATA_WIDTH-1:0]   WrData_DI,
  output logic [ARB_NUM_REQ-1:0]                   RValid_SO,
  output logic [DATA_WIDTH-1:0]                    RdData_DO,
  output logic                                     Sram_CSel_SO,
  output logic                                     Sram_WrEn_SO,
  output logic [DATA_WIDTH/8-1:0]                  Sram_BEn_SO,
  output logic [ADDR_WIDTH-1:0]                    Sram_Addr_DO,
  output logic [DATA_WIDTH-1:0]                    Sram_WrData_DO,
  input  logic [DATA_WIDTH-1:0]                    Sram_RdData_DI
);

  arb_state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]         cnt_q, cnt_d;
  logic [ARB_NUM_REQ-1:0]        rvalid_q;
  logic [ARB_NUM_REQ-1:0]        gnt;
  logic                          sel;

  rr_arbiter_2 u_rr (
    .clk (Clk_CI),
    .rst (Rst_RI),
    .en  (state_q == ARB_RUN),
    .req (Req_SI),
    .gnt (gnt)
  );

  assign sel = gnt[1];

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= INIT_ON_RESET ? ARB_INIT : ARB_RUN;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~WrEn_SI;
    end
  end

  // Init_SI overrides whatever the current state would do next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ARB_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
        state_d = ARB_RUN;
        cnt_d   = '0;
      end
    end
    if (Init_SI) begin
      state_d = ARB_INIT;
      cnt_d   = '0;
    end
  end

  // The wrapper's byte enables are active-low, the requesters' active-high.
  always_comb begin
    Sram_CSel_SO   = 1'b0;
    Sram_WrEn_SO   = 1'b0;
    Sram_BEn_SO    = '1;
    Sram_Addr_DO   = '0;
    Sram_WrData_DO = '0;
    if (state_q == ARB_INIT) begin
      Sram_CSel_SO   = 1'b1;
      Sram_WrEn_SO   = 1'b1;
      Sram_BEn_SO    = '0;
      Sram_Addr_DO   = cnt_q;
      Sram_WrData_DO = INIT_VALUE;
    end else if (|gnt) begin
      Sram_CSel_SO   = 1'b1;
      Sram_WrEn_SO   = WrEn_SI[sel];
      Sram_BEn_SO    = ~BEn_SI[sel];
      Sram_Addr_DO   = Addr_DI[sel];
      Sram_WrData_DO = WrData_DI[sel];
    end
  end

  assign Gnt_SO      = gnt;
  assign RValid_SO   = rvalid_q;
  assign RdData_DO   = Sram_RdData_DI;
  assign InitDone_SO = (state_q == ARB_RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a behavioural SRAM wrapper, a
// requester-level reference memory, and a monitor that matches read responses.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int DW = ARB_DATA_WIDTH;
  localparam int AW = 8;
  localparam int NW = 256;
  localparam int BW = BE_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst, init, init_done;
  logic [1:0]           req, gnt, we, rvalid;
  logic [1:0][BW-1:0]   ben;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][DW-1:0]   wdata;
  logic [DW-1:0]        rdata;
  logic                 s_csel, s_wren;
  logic [BW-1:0]        s_ben;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wdata;
  logic [DW-1:0]        s_rdata = '0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .Clk_CI         (clk),
    .Rst_RI         (rst),
    .Init_SI        (init),
    .InitDone_SO    (init_done),
    .Req_SI         (req),
    .Gnt_SO         (gnt),
    .WrEn_SI        (we),
    .BEn_SI         (ben),
    .Addr_DI        (addr),
    .WrData_DI      (wdata),
    .RValid_SO      (rvalid),
    .RdData_DO      (rdata),
    .Sram_CSel_SO   (s_csel),
    .Sram_WrEn_SO   (s_wren),
    .Sram_BEn_SO    (s_ben),
    .Sram_Addr_DO   (s_addr),
    .Sram_WrData_DO (s_wdata),
    .Sram_RdData_DI (s_rdata)
  );

  // Wrapper model: active-low byte enables, registered read data.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (s_csel) begin
      if (s_wren) begin
        for (int b = 0; b < BW; b++)
          if (!s_ben[b]) sram_mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        s_rdata <= sram_mem[s_addr];
      end
    end
  end

  typedef struct { int id; int t; logic [DW-1:0] data; } rsp_t;
  rsp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state, at the level of requester transactions.
  bit            m_run;
  int            m_cnt, m_fav, m_g;
  logic [DW-1:0] ref_mem [NW];
  logic [1:0]    cap_gnt;
  logic [BW-1:0] cap_sben;

  logic [1:0]         pr, pw;
  logic [1:0][BW-1:0] pb;
  logic [1:0][AW-1:0] pa;
  logic [1:0][DW-1:0] pd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 64'(rvalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_owner", 64'(rvalid), 64'(1 << e.id));
        chk("rvalid_cycle", 64'(cyc), 64'(e.t + 1));
        chk("rdata", rdata, e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].t < cyc) begin
      e = exp_q.pop_front();
      chk("rvalid_missing", 64'd0, 64'(1 << e.id));
    end
  end

  task automatic checkOutput();
    int            g;
    logic [1:0]    eg;
    logic [BW-1:0] nb;
    g = -1;
    if (m_run) begin
      if (req == 2'b11)      g = m_fav;
      else if (req == 2'b01) g = 0;
      else if (req == 2'b10) g = 1;
    end
    eg = (g < 0) ? 2'b00 : 2'(1 << g);
    cap_gnt  = gnt;
    cap_sben = s_ben;
    m_g      = g;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("init_done", 64'(init_done), 64'(m_run));
    if (!m_run) begin
      chk("sweep_csel", 64'(s_csel), 64'd1);
      chk("sweep_wren", 64'(s_wren), 64'd1);
      chk("sweep_ben", 64'(s_ben), 64'd0);
      chk("sweep_addr", 64'(s_addr), 64'(m_cnt));
      chk("sweep_wdata", s_wdata, 64'd0);
    end else if (g >= 0) begin
      nb = ~ben[g];
      chk("csel", 64'(s_csel), 64'd1);
      chk("wren", 64'(s_wren), 64'(we[g]));
      chk("sram_ben", 64'(s_ben), 64'(nb));
      chk("addr", 64'(s_addr), 64'(addr[g]));
      if (we[g]) chk("wdata", s_wdata, wdata[g]);
    end else begin
      chk("csel_idle", 64'(s_csel), 64'd0);
    end
    if (g >= 0) begin
      if (we[g]) begin
        for (int b = 0; b < BW; b++)
          if (ben[g][b]) ref_mem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
      end else if (!rst) begin
        exp_q.push_back('{id: g, t: cyc, data: ref_mem[addr[g]]});
      end
      if (req == 2'b11) m_fav = 1 - g;
    end
    if (rst) begin
      m_run = 1'b0; m_cnt = 0; m_fav = 0; clear_ref();
    end else if (init) begin
      m_run = 1'b0; m_cnt = 0; clear_ref();
    end else if (!m_run) begin
      if (m_cnt == NW - 1) begin m_run = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [1:0][BW-1:0] be, input logic [1:0][AW-1:0] a,
                               input logic [1:0][DW-1:0] d, input logic in_init,
                               input logic in_rst);
    @(posedge clk);
    #1;
    req = r; we = w; ben = be; addr = a; wdata = d; init = in_init; rst = in_rst;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic single(input int id, input logic w, input logic [BW-1:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic in_init, input logic in_rst);
    logic [1:0]         r, wv;
    logic [1:0][BW-1:0] bv;
    logic [1:0][AW-1:0] av;
    logic [1:0][DW-1:0] dv;
    r = '0; wv = '0; bv = '0; av = '0; dv = '0;
    r[id] = 1'b1; wv[id] = w; bv[id] = be; av[id] = a; dv[id] = d;
    applyStimulus(r, wv, bv, av, dv, in_init, in_rst);
  endtask

  // Holds both requesters reading until the sweep ends; returns cycles seen in INIT.
  task automatic wait_sweep(input int already, output int n);
    n = already;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(2'b11, 2'b00, '0, {8'h20, 8'h10}, '0, 1'b0, 1'b0);
      if (init_done) break;
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < NW; i++) sram_mem[i] = {$urandom, $urandom};
    rst = 1'b1; init = 1'b0; req = 2'b11; we = 2'b00; ben = '0; addr = '0; wdata = '0;
    m_run = 1'b0; m_cnt = 0; m_fav = 0; m_g = -1;
    clear_ref();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_init_done", 64'(init_done), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_sweep_addr", 64'(s_addr), 64'd0);

    $display("[TB] sweep after reset");
    n = 0;
    for (int k = 0; k < 300; k++) begin
      idle(1);
      if (init_done) break;
      n++;
    end
    chk("sweep_length", 64'(n), 64'd256);
    single(0, 1'b0, '0, 8'h00, '0, 1'b0, 1'b0);
    single(1, 1'b0, '0, 8'h7F, '0, 1'b0, 1'b0);
    single(0, 1'b0, '0, 8'hFF, '0, 1'b0, 1'b0);
    idle(1);

    $display("[TB] write then read from the other requester");
    single(0, 1'b1, 8'hFF, 8'h10, 64'hA5, 1'b0, 1'b0);
    single(1, 1'b0, '0, 8'h10, '0, 1'b0, 1'b0);
    idle(1);
    chk("t2_rvalid", 64'(rvalid), 64'h2);
    chk("t2_rdata", rdata, 64'hA5);

    $display("[TB] round-robin under contention");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 2'b00, '0, {8'h02, 8'h01}, '0, 1'b0, 1'b0);
      chk($sformatf("t3_alt_gnt%0d", k), 64'(cap_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 2'b00, '0, {8'h02, 8'h01}, '0, 1'b0, 1'b0);
      chk($sformatf("t3_lone_gnt%0d", k), 64'(cap_gnt), 64'h2);
    end
    applyStimulus(2'b11, 2'b00, '0, {8'h02, 8'h01}, '0, 1'b0, 1'b0);
    chk("t3_ptr_kept", 64'(cap_gnt), 64'h1);
    idle(2);

    $display("[TB] partial byte write");
    single(0, 1'b1, 8'h01, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("t4_sram_ben", 64'(cap_sben), 64'hFE);
    single(1, 1'b0, '0, 8'h20, '0, 1'b0, 1'b0);
    idle(1);
    chk("t4_rdata", rdata, 64'hFF);

    $display("[TB] init request alongside a read");
    single(0, 1'b0, '0, 8'h10, '0, 1'b1, 1'b0);
    idle(1);
    chk("t5_rvalid", 64'(rvalid), 64'h1);
    chk("t5_rdata", rdata, 64'hA5);
    wait_sweep(1, n);
    chk("t5_sweep_length", 64'(n), 64'd256);
    idle(1);
    single(1, 1'b0, '0, 8'h20, '0, 1'b0, 1'b0);
    idle(1);
    chk("t5_cleared", rdata, 64'd0);

    $display("[TB] reset on a read grant");
    single(0, 1'b0, '0, 8'h10, '0, 1'b0, 1'b1);
    applyStimulus(2'b11, 2'b00, '0, {8'h20, 8'h10}, '0, 1'b0, 1'b0);
    chk("t6_rvalid", 64'(rvalid), 64'd0);
    chk("t6_sweep_addr", 64'(s_addr), 64'd0);
    chk("t6_gnt", 64'(gnt), 64'd0);
    wait_sweep(1, n);
    chk("t6_sweep_length", 64'(n), 64'd256);

    $display("[TB] random traffic");
    pr = '0; pw = '0; pb = '0; pa = '0; pd = '0;
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pr[i] || m_g == i) begin
          pr[i] = ($urandom_range(3) != 0);
          pw[i] = 1'($urandom_range(1));
          pb[i] = ($urandom_range(7) == 0) ? '0 : BW'($urandom);
          pa[i] = AW'($urandom_range(15));
          pd[i] = {$urandom, $urandom};
        end
      end
      applyStimulus(pr, pw, pb, pa, pd, 1'b0, 1'b0);
    end
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
